// File: rtl/display_pkg.sv
// Shared types, constants and lookups for the 4-digit BCD scan display path.
package display_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_t;

  localparam int unsigned MAX_DISPLAY = 9999;
  localparam int unsigned CONV_CYCLES = 14;
  localparam int unsigned BIN_W       = 14;

  // Digit index to active-low one-hot anode pattern.
  function automatic logic [3:0] anode_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] acc);
    logic [15:0] r;
    r = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary (saturated to 9999) into four BCD
// digits, one iteration per cycle; result/done are valid on the final iteration.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic [15:0]      result,
  output logic             done
);

  localparam logic [BIN_W-1:0] SAT = BIN_W'(MAX_DISPLAY);

  conv_state_t      state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [29:0]      shifted;

  // Adjusted accumulator and remaining binary shift together as one word.
  assign shifted = {dabble_adjust(acc_q), bin_q} << 1;
  assign result  = shifted[29:14];
  assign done    = (state_q == CONVERT) && (cnt_q == 4'(CONV_CYCLES - 1));
  assign busy    = busy_q;
  assign ovf     = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = (value > SAT) ? SAT : value;
          ovf_d   = (value > SAT);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        acc_d = shifted[29:14];
        bin_d = shifted[13:0];
        cnt_d = cnt_q + 4'd1;
        if (done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter plus 4-digit time-multiplexed scan (bcd bus + active-low anodes).
// Optional LEADING_ZERO_BLANK_EN darkens digits above the most significant non-zero one.
module bcd_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIGITS      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output bcd_digit_t       bcd,
  output logic [3:0]       an
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DIGITS);

  logic [15:0]      conv_result;
  logic             conv_done;
  logic [15:0]      disp_q, disp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  bcd_digit_t       bcd_q, bcd_d;
  logic             lit;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .reset  (reset),
    .value  (value),
    .load   (load),
    .busy   (busy),
    .ovf    (ovf),
    .result (conv_result),
    .done   (conv_done)
  );

  always_comb begin
    disp_d = conv_done ? conv_result : disp_q;
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = IDX_W'(idx_q + 1'b1);
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Lit if units, or if this digit or any above it is non-zero.
    lit = (idx_q == '0) || (|(disp_q >> {idx_q, 2'b00}));
`else
    lit = 1'b1;
`endif
    an_d  = lit ? anode_pattern(idx_q) : 4'b1111;
    bcd_d = disp_q[{idx_q, 2'b00} +: 4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1111;
      bcd_q  <= '0;
    end else begin
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      bcd_q  <= bcd_d;
    end
  end

  assign an  = an_q;
  assign bcd = bcd_q;

endmodule
